// File: rtl/imem_loader_if.sv
// Stream-in and instruction-memory bus signals of the program loader.
// The master modport is the loader side; the slave modport is the source/memory side.
interface imem_loader_if #(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DATA_W = 32
);
   logic              s_valid;
   logic [DATA_W-1:0] s_data;
   logic              s_ready;
   logic [ADDR_W-1:0] addr_ext;
   logic              wen_ext;
   logic              ren_ext;
   logic [DATA_W-1:0] wdata_ext;
   logic [DATA_W-1:0] rdata_ext;

   modport master (
      input  s_valid, s_data, rdata_ext,
      output s_ready, addr_ext, wen_ext, ren_ext, wdata_ext
   );

   modport slave (
      output s_valid, s_data, rdata_ext,
      input  s_ready, addr_ext, wen_ext, ren_ext, wdata_ext
   );
endinterface

// File: rtl/imem_loader.sv
// Streams a program image into instruction memory, reads it back to verify the checksum,
// then releases the processor (or flags an error and keeps it halted).
module imem_loader #(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 8
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              start,
   input  logic [CNT_W-1:0]  num_words,
   imem_loader_if.master     bus,
   output logic              cpu_enable,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [DATA_W-1:0] checksum
);

   typedef enum logic [2:0] {
      StIdle, StLoad, StWflush, StVerify, StCheck, StRun, StError
   } state_e;

   state_e            state_q;
   logic [CNT_W-1:0]  n_q;
   logic [CNT_W-1:0]  wr_idx_q;
   logic [CNT_W-1:0]  rd_idx_q;
   logic [DATA_W-1:0] wr_sum_q;
   logic [DATA_W-1:0] rd_sum_q;
   logic [DATA_W-1:0] wr_sum_d;
   logic [DATA_W-1:0] rd_sum_d;
   logic              rd_vld_q;
   logic              hs;

   logic              s_ready_q;
   logic              wen_q;
   logic              ren_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;

   assign bus.s_ready   = s_ready_q;
   assign bus.wen_ext   = wen_q;
   assign bus.ren_ext   = ren_q;
   assign bus.addr_ext  = addr_q;
   assign bus.wdata_ext = wdata_q;

   // rd_vld_q marks the cycle in which rdata_ext answers the previous read strobe.
   always_comb begin
      hs       = s_ready_q & bus.s_valid;
      wr_sum_d = wr_sum_q + (hs ? bus.s_data : '0);
      rd_sum_d = rd_sum_q + (rd_vld_q ? bus.rdata_ext : '0);
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q    <= StIdle;
         n_q        <= '0;
         wr_idx_q   <= '0;
         rd_idx_q   <= '0;
         wr_sum_q   <= '0;
         rd_sum_q   <= '0;
         rd_vld_q   <= 1'b0;
         s_ready_q  <= 1'b0;
         wen_q      <= 1'b0;
         ren_q      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         cpu_enable <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         checksum   <= '0;
      end else begin
         rd_vld_q <= ren_q;
         rd_sum_q <= rd_sum_d;
         wen_q    <= 1'b0;
         ren_q    <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;

         unique case (state_q)
            StIdle, StRun, StError: begin
               if (start) begin
                  error <= 1'b0;
                  if (num_words == '0) begin
                     state_q    <= StRun;
                     cpu_enable <= 1'b1;
                     done       <= 1'b1;
                     busy       <= 1'b0;
                  end else begin
                     state_q    <= StLoad;
                     n_q        <= num_words;
                     wr_idx_q   <= '0;
                     rd_idx_q   <= '0;
                     wr_sum_q   <= '0;
                     rd_sum_q   <= '0;
                     s_ready_q  <= 1'b1;
                     busy       <= 1'b1;
                     cpu_enable <= 1'b0;
                     done       <= 1'b0;
                  end
               end
            end

            StLoad: begin
               wr_sum_q <= wr_sum_d;
               checksum <= wr_sum_d;
               if (hs) begin
                  wen_q    <= 1'b1;
                  addr_q   <= ADDR_W'(wr_idx_q) << 2;
                  wdata_q  <= bus.s_data;
                  wr_idx_q <= wr_idx_q + CNT_W'(1);
                  if (wr_idx_q == n_q - CNT_W'(1)) begin
                     s_ready_q <= 1'b0;
                     state_q   <= StWflush;
                  end
               end
            end

            // Final write is on the bus this cycle; queue the first read behind it.
            StWflush: begin
               ren_q    <= 1'b1;
               addr_q   <= '0;
               rd_idx_q <= CNT_W'(1);
               state_q  <= StVerify;
            end

            StVerify: begin
               if (rd_idx_q == n_q) begin
                  state_q <= StCheck;
               end else begin
                  ren_q    <= 1'b1;
                  addr_q   <= ADDR_W'(rd_idx_q) << 2;
                  rd_idx_q <= rd_idx_q + CNT_W'(1);
               end
            end

            // Compare against the sum including the last read word, which lands this cycle.
            StCheck: begin
               busy <= 1'b0;
               if (wr_sum_q == rd_sum_d) begin
                  state_q    <= StRun;
                  cpu_enable <= 1'b1;
                  done       <= 1'b1;
               end else begin
                  state_q <= StError;
                  error   <= 1'b1;
               end
            end

            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader: memory responder, bus monitor and an
// image-level reference (expected writes, reads, checksum, status and timing).
module tb_imem_loader;
   localparam int unsigned ADDR_W = 64;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 8;

   logic              clk = 1'b0;
   logic              arst_n = 1'b0;
   logic              start = 1'b0;
   logic [CNT_W-1:0]  num_words = '0;
   logic              cpu_enable;
   logic              busy;
   logic              done;
   logic              error;
   logic [DATA_W-1:0] checksum;

   imem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .arst_n     (arst_n),
      .start      (start),
      .num_words  (num_words),
      .bus        (bus),
      .cpu_enable (cpu_enable),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .checksum   (checksum)
   );

   always #5 clk = ~clk;

   int errs   = 0;
   int checks = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Instruction memory responder: read data arrives the cycle after ren_ext.
   logic [DATA_W-1:0] mem [256];
   bit                corrupt = 1'b0;
   always @(posedge clk) begin
      if (bus.wen_ext) mem[bus.addr_ext[9:2]] <= bus.wdata_ext;
      if (bus.ren_ext)
         bus.rdata_ext <= (corrupt && bus.addr_ext == 64'd8) ? 32'h002081B2
                                                             : mem[bus.addr_ext[9:2]];
      else
         bus.rdata_ext <= '0;
   end

   // Bus monitor.
   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [63:0] wr_addr_q [$];
   logic [31:0] wr_data_q [$];
   int unsigned wr_cyc_q  [$];
   logic [63:0] rd_addr_q [$];
   int unsigned rd_cyc_q  [$];
   int          bad_cnt = 0;

   always @(negedge clk) begin
      if (bus.wen_ext) begin
         wr_addr_q.push_back(bus.addr_ext);
         wr_data_q.push_back(bus.wdata_ext);
         wr_cyc_q.push_back(cyc);
      end
      if (bus.ren_ext) begin
         rd_addr_q.push_back(bus.addr_ext);
         rd_cyc_q.push_back(cyc);
      end
      if ((bus.wen_ext && bus.ren_ext) ||
          (!bus.wen_ext && !bus.ren_ext && (bus.addr_ext != '0 || bus.wdata_ext != '0)))
         bad_cnt++;
   end

   logic [31:0] words [256];

   task automatic clear_log();
      @(posedge clk);
      #1;
      wr_addr_q.delete();
      wr_data_q.delete();
      wr_cyc_q.delete();
      rd_addr_q.delete();
      rd_cyc_q.delete();
   endtask

   // gap_mode: 0 back-to-back, 1 valid on alternate cycles, 2 random valid.
   task automatic run_load(input int n, input int gap_mode, input bit corr, input bit poke);
      int unsigned hs_cyc [$];
      int          i;
      int          budget;
      int          k;
      bit          hs;
      bit          poked;
      bit          ok;
      logic [31:0] wsum;
      logic [31:0] rsum;
      int unsigned status_cyc;
      int unsigned last_wr;

      corrupt = corr;
      clear_log();
      @(negedge clk);
      start     = 1'b1;
      num_words = CNT_W'(n);
      @(negedge clk);
      start = 1'b0;
      check_val("busy_after_start", 64'(busy), 64'd1);
      check_val("cpu_en_drops_on_start", 64'(cpu_enable), 64'd0);
      check_val("s_ready_in_load", 64'(bus.s_ready), 64'd1);

      i      = 0;
      budget = 0;
      while (i < n && budget < 8 * n + 50) begin
         case (gap_mode)
            1:       bus.s_valid = (budget % 2 == 0);
            2:       bus.s_valid = 1'($urandom_range(0, 1));
            default: bus.s_valid = 1'b1;
         endcase
         bus.s_data = words[i];
         hs = bus.s_valid && bus.s_ready;
         if (hs) hs_cyc.push_back(cyc);
         @(negedge clk);
         if (hs) i++;
         budget++;
      end
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      check_val("stream_accepted", 64'(i), 64'(n));

      budget = 0;
      poked  = 1'b0;
      while (!(done || error) && budget < n + 20) begin
         if (poke && !poked && bus.ren_ext) begin
            start     = 1'b1;
            num_words = '0;
            poked     = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         budget++;
      end
      start      = 1'b0;
      status_cyc = cyc;
      check_val("status_reached", 64'(done || error), 64'd1);

      wsum = '0;
      rsum = '0;
      for (int j = 0; j < n; j++) begin
         wsum += words[j];
         rsum += (corr && j == 2) ? 32'h002081B2 : words[j];
      end
      ok = (wsum == rsum);
      check_val("done", 64'(done), 64'(ok));
      check_val("error", 64'(error), 64'(!ok));
      check_val("cpu_enable", 64'(cpu_enable), 64'(ok));
      check_val("busy_idle", 64'(busy), 64'd0);
      check_val("checksum", 64'(checksum), 64'(wsum));

      check_val("write_count", 64'(wr_addr_q.size()), 64'(n));
      for (k = 0; k < n && k < wr_addr_q.size() && k < hs_cyc.size(); k++) begin
         check_val("write_addr", wr_addr_q[k], 64'(4 * k));
         check_val("write_data", 64'(wr_data_q[k]), 64'(words[k]));
         check_val("write_cycle", 64'(wr_cyc_q[k]), 64'(hs_cyc[k] + 1));
      end
      last_wr = (wr_cyc_q.size() > 0) ? wr_cyc_q[wr_cyc_q.size() - 1] : 0;
      check_val("read_count", 64'(rd_addr_q.size()), 64'(n));
      for (k = 0; k < n && k < rd_addr_q.size(); k++) begin
         check_val("read_addr", rd_addr_q[k], 64'(4 * k));
         check_val("read_cycle", 64'(rd_cyc_q[k]), 64'(last_wr + 1 + k));
      end
      check_val("status_cycle", 64'(status_cyc), 64'(last_wr + n + 2));
      check_val("bus_idle_rules", 64'(bad_cnt), 64'd0);
      corrupt = 1'b0;
   endtask

   task automatic load_nominal();
      words[0] = 32'h00500093;
      words[1] = 32'h00100113;
      words[2] = 32'h002081B3;
      words[3] = 32'h00000013;
   endtask

   initial begin
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      #23;
      check_val("reset_outputs", 64'({bus.s_ready, bus.wen_ext, bus.ren_ext, cpu_enable,
                                      busy, done, error}), 64'd0);
      check_val("reset_addr", bus.addr_ext, 64'd0);
      check_val("reset_checksum", 64'(checksum), 64'd0);
      @(negedge clk);
      arst_n = 1'b1;
      @(negedge clk);
      check_val("s_ready_after_release", 64'(bus.s_ready), 64'd0);
      check_val("idle_not_done", 64'({busy, done, error, cpu_enable}), 64'd0);

      // Nominal image, back-to-back; checksum also checked as a constant.
      load_nominal();
      run_load(4, 0, 1'b0, 1'b0);
      check_val("nominal_checksum", 64'(checksum), 64'h0080836C);

      // Restart from RUN with backpressure.
      run_load(4, 1, 1'b0, 1'b0);

      // Corrupted readback at address 8.
      run_load(4, 0, 1'b1, 1'b0);

      // Start from ERROR, with a start pulse during VERIFY that must be ignored.
      run_load(4, 0, 1'b0, 1'b1);

      // Zero-length image.
      clear_log();
      @(negedge clk);
      start     = 1'b1;
      num_words = '0;
      @(negedge clk);
      start = 1'b0;
      check_val("n0_done", 64'({done, cpu_enable}), 64'd3);
      check_val("n0_busy_error", 64'({busy, error, bus.s_ready}), 64'd0);
      @(negedge clk);
      check_val("n0_no_strobes", 64'(wr_addr_q.size() + rd_addr_q.size()), 64'd0);

      // Reset after two of four words.
      clear_log();
      @(negedge clk);
      start     = 1'b1;
      num_words = 8'd4;
      @(negedge clk);
      start       = 1'b0;
      bus.s_valid = 1'b1;
      bus.s_data  = words[0];
      @(negedge clk);
      bus.s_data = words[1];
      @(negedge clk);
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      #2;
      arst_n = 1'b0;
      #1;
      check_val("midload_rst_outputs", 64'({bus.s_ready, bus.wen_ext, bus.ren_ext, cpu_enable,
                                            busy, done, error}), 64'd0);
      check_val("midload_rst_addr", bus.addr_ext, 64'd0);
      check_val("midload_rst_wdata", 64'(bus.wdata_ext), 64'd0);
      check_val("midload_rst_checksum", 64'(checksum), 64'd0);
      @(negedge clk);
      arst_n = 1'b1;
      run_load(4, 0, 1'b0, 1'b0);

      // Randomized images and stream gaps.
      for (int r = 0; r < 8; r++) begin
         int n;
         n = int'($urandom_range(1, 24));
         for (int j = 0; j < n; j++) words[j] = $urandom;
         run_load(n, int'($urandom_range(0, 2)), 1'b0, 1'($urandom_range(0, 1)));
      end

      // Maximum-length image.
      for (int j = 0; j < 255; j++) words[j] = $urandom;
      run_load(255, 0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
